serial_operand_feeder: RTL and testbench

Parallel-to-serial front end for the two-operand serial adder. It accepts a pair of WIDTH-bit operands through a ready/start handshake and clears the downstream adder for one cycle. It then presents the operand bits LSB-first, one bit pair per clock, and flags the cycle in which the adder's final sum bit and carry are valid. It sits directly upstream of the serial adder and drives its a, b and synchronous active-high clear inputs.

---
 rtl/serial_operand_feeder_if.sv | 26 ++
 rtl/serial_operand_feeder.sv | 106 ++++++++++
 tb/tb_serial_operand_feeder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/serial_operand_feeder_if.sv
// Handshake and serial-bit bundle between the operand source, the feeder
// and the downstream serial adder.
interface serial_operand_feeder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             add_clr;
    logic             a_bit;
    logic             b_bit;
    logic             bit_valid;
    logic             last_bit;
    logic             done;

    modport master (
        output start, a_in, b_in,
        input  ready, add_clr, a_bit, b_bit, bit_valid, last_bit, done
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, add_clr, a_bit, b_bit, bit_valid, last_bit, done
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial front end for a two-operand serial adder: captures a
// pair of operands, clears the adder for one cycle, streams the bit pairs
// LSB-first and pulses done when the adder's final sum bit and carry are valid.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_operand_feeder_if.slave  sof
);
    localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_PENUL = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_add_clr;
    logic             r_a_bit;
    logic             r_b_bit;
    logic             r_bit_valid;
    logic             r_last_bit;
    logic             r_done;

    // FSM, shift registers and every output register; outputs are set for
    // the state being entered, so serial bits are taken from the LSB that
    // will sit in position 0 after this edge's shift (bit 1 before it).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_add_clr   <= 1'b0;
            r_a_bit     <= 1'b0;
            r_b_bit     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sof.start) begin
                        r_a_sh    <= sof.a_in;
                        r_b_sh    <= sof.b_in;
                        r_cnt     <= '0;
                        r_state   <= S_CLEAR;
                        r_ready   <= 1'b0;
                        r_add_clr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_SHIFT;
                    r_add_clr   <= 1'b0;
                    r_bit_valid <= 1'b1;
                    r_a_bit     <= r_a_sh[0];
                    r_b_bit     <= r_b_sh[0];
                    r_last_bit  <= 1'b0;
                end
                S_SHIFT: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state     <= S_DONE;
                        r_bit_valid <= 1'b0;
                        r_a_bit     <= 1'b0;
                        r_b_bit     <= 1'b0;
                        r_last_bit  <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_a_bit    <= r_a_sh[1];
                        r_b_bit    <= r_b_sh[1];
                        r_last_bit <= (r_cnt == C_PENUL);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sof.ready     = r_ready;
    assign sof.add_clr   = r_add_clr;
    assign sof.a_bit     = r_a_bit;
    assign sof.b_bit     = r_b_bit;
    assign sof.bit_valid = r_bit_valid;
    assign sof.last_bit  = r_last_bit;
    assign sof.done      = r_done;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: WIDTH=8 and WIDTH=2 instances,
// with a small serial adder model attached to the 8-bit instance.
module tb_serial_operand_feeder;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_operand_feeder_if #(.WIDTH(8)) bus8 ();
    serial_operand_feeder_if #(.WIDTH(2)) bus2 ();

    serial_operand_feeder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .sof(bus8.slave));
    serial_operand_feeder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .sof(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream serial adder: synchronous clear, registered sum and carry.
    logic s8;
    logic c8;
    always_ff @(posedge clk) begin
        if (bus8.add_clr) begin
            s8 <= 1'b0;
            c8 <= 1'b0;
        end else begin
            s8 <= bus8.a_bit ^ bus8.b_bit ^ c8;
            c8 <= (bus8.a_bit & bus8.b_bit) | (bus8.a_bit & c8) | (bus8.b_bit & c8);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is inside cycle 0; returns inside cycle WIDTH+3 (= 11).
    task automatic run_word(input logic [7:0] a, input logic [7:0] b, input logic hold,
                            input logic perturb, input logic [7:0] exp_sum, input logic exp_c);
        logic [7:0] ga;
        logic [7:0] gb;
        logic [7:0] gs;
        ga = '0;
        gb = '0;
        gs = '0;
        bus8.start = 1'b1;
        bus8.a_in  = a;
        bus8.b_in  = b;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1 && !hold) bus8.start = 1'b0;
            if (perturb && c == 4) bus8.start = 1'b1;
            if (perturb && c == 5) begin
                bus8.start = 1'b0;
                bus8.a_in  = 8'hAA;
                bus8.b_in  = 8'h55;
            end
            if (c <= 10) chk("ready_low", bus8.ready, 1'b0);
            chk("add_clr", bus8.add_clr, (c == 1));
            chk("done", bus8.done, (c == 10));
            chk("last_bit", bus8.last_bit, (c == 9));
            if (c >= 2 && c <= 9) begin
                chk("bit_valid", bus8.bit_valid, 1'b1);
                ga[c-2] = bus8.a_bit;
                gb[c-2] = bus8.b_bit;
            end else begin
                chk("bit_valid_off", bus8.bit_valid, 1'b0);
                chk("a_bit_off", bus8.a_bit, 1'b0);
                chk("b_bit_off", bus8.b_bit, 1'b0);
            end
            if (c >= 3 && c <= 10) gs[c-3] = s8;
            if (c == 10) chk("carry", c8, exp_c);
            if (c == 11) chk("ready_back", bus8.ready, 1'b1);
        end
        chk("a_serial", ga, a);
        chk("b_serial", gb, b);
        chk("sum", gs, exp_sum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus8.start = 1'b0;
        bus8.a_in  = '0;
        bus8.b_in  = '0;
        bus2.start = 1'b0;
        bus2.a_in  = '0;
        bus2.b_in  = '0;
        tick();
        tick();
        chk("rst_ready", bus8.ready, 1'b1);
        chk("rst_add_clr", bus8.add_clr, 1'b0);
        chk("rst_bits", {bus8.a_bit, bus8.b_bit}, 2'b00);
        chk("rst_valid", bus8.bit_valid, 1'b0);
        chk("rst_last", bus8.last_bit, 1'b0);
        chk("rst_done", bus8.done, 1'b0);
        rst = 1'b1;
        tick();
        chk("idle_ready", bus8.ready, 1'b1);

        // Basic word: 0x5A + 0x3C = 0x96, carry 0.
        run_word(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        // 0xFF + 0x01 = 0x100.
        tick();
        run_word(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

        // Start held high: acceptance at every 11th edge, back to back.
        tick();
        run_word(8'h12, 8'h34, 1'b1, 1'b0, 8'h46, 1'b0);
        run_word(8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 1'b1);
        run_word(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0);

        // Start pulse and operand change during SHIFT are ignored.
        tick();
        run_word(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0);

        // Reset in cycle 5 abandons the word.
        tick();
        bus8.start = 1'b1;
        bus8.a_in  = 8'hC3;
        bus8.b_in  = 8'h99;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_valid", bus8.bit_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", bus8.ready, 1'b1);
        chk("mid_rst_valid", bus8.bit_valid, 1'b0);
        chk("mid_rst_add_clr", bus8.add_clr, 1'b0);
        chk("mid_rst_done", bus8.done, 1'b0);
        chk("mid_rst_bits", {bus8.a_bit, bus8.b_bit}, 2'b00);
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("no_done_after_rst", bus8.done, 1'b0);
            chk("idle_after_rst", bus8.ready, 1'b1);
        end
        run_word(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

        // WIDTH=2 instance: 2'b11 and 2'b01.
        tick();
        bus2.start = 1'b1;
        bus2.a_in  = 2'b11;
        bus2.b_in  = 2'b01;
        tick();
        bus2.start = 1'b0;
        chk("w2_c1_clr", bus2.add_clr, 1'b1);
        chk("w2_c1_ready", bus2.ready, 1'b0);
        tick();
        chk("w2_c2_bits", {bus2.bit_valid, bus2.a_bit, bus2.b_bit, bus2.last_bit}, 4'b1110);
        tick();
        chk("w2_c3_bits", {bus2.bit_valid, bus2.a_bit, bus2.b_bit, bus2.last_bit}, 4'b1101);
        tick();
        chk("w2_c4_done", {bus2.done, bus2.bit_valid, bus2.ready}, 3'b100);
        tick();
        chk("w2_c5_ready", {bus2.done, bus2.ready}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
